// File: rtl/stream_take_n_if.sv
`default_nettype none
// ============================================================================
//  Module  : stream_take_n_if
//  Brief   : Valid/ready stream bundle with producer and consumer views.
//  Revision: 1.0 - initial release
// ============================================================================
interface stream_take_n_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/stream_take_n.sv
`default_nettype none
// ============================================================================
//  Module  : stream_take_n
//  Brief   : Captures the first COUNT stream elements into parallel slots and
//            forwards the remaining elements through a small tail FIFO.
//  Revision: 1.0 - initial release
// ============================================================================
module stream_take_n #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 2,
    parameter int BUF_DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   nrst,
    stream_take_n_if.slave              in_s,
    stream_take_n_if.master             out_m,
    output logic [COUNT*WIDTH-1:0]      take_data,
    output logic                        take_valid,
    input  wire logic                   restart
);

    localparam int c_IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [0:0] {
        S_CAPTURE = 1'b0,
        S_PASS    = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [COUNT*WIDTH-1:0] r_slots;
    logic                   r_take_valid;
    logic                   r_pending;
    logic [WIDTH-1:0]       r_mem [BUF_DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_CNT_W-1:0]     r_count;

    logic w_in_ready;
    logic w_capture;
    logic w_capture_last;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drain_done;

    assign w_full  = (r_count == c_CNT_W'(BUF_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_m.ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_in_ready     = 1'b0;
        w_capture      = 1'b0;
        w_capture_last = 1'b0;
        w_push         = 1'b0;
        w_drain_done   = 1'b0;
        case (r_state)
            S_CAPTURE: begin
                w_in_ready     = !r_pending;
                w_capture      = in_s.valid && w_in_ready;
                w_capture_last = w_capture && (r_idx == c_IDX_W'(COUNT - 1));
                // A restart on the final head transfer keeps us capturing afresh
                if (w_capture_last && !restart) begin
                    w_state_nxt = S_PASS;
                end
            end
            S_PASS: begin
                w_in_ready = !w_full && !r_pending;
                w_push     = in_s.valid && w_in_ready;
                if (r_pending && (w_empty || (r_count == c_CNT_W'(1) && w_pop))) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = S_CAPTURE;
                end
            end
            default: begin
                w_state_nxt = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx        <= '0;
            r_slots      <= '0;
            r_take_valid <= 1'b0;
            r_pending    <= 1'b0;
        end else if (w_drain_done) begin
            r_idx        <= '0;
            r_slots      <= '0;
            r_take_valid <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            for (int i = 0; i < COUNT; i++) begin
                if (w_capture && (r_idx == c_IDX_W'(i))) begin
                    r_slots[i*WIDTH +: WIDTH] <= in_s.data;
                end
            end
            if (r_state == S_CAPTURE && restart) begin
                r_idx <= '0;
            end else if (w_capture) begin
                r_idx <= w_capture_last ? '0 : r_idx + c_IDX_W'(1);
            end
            if (w_capture_last && !restart) begin
                r_take_valid <= 1'b1;
            end
            if (r_state == S_PASS && restart) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= in_s.data;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_s.ready  = w_in_ready;
    assign out_m.valid = !w_empty;
    assign out_m.data  = r_mem[r_rptr];
    assign take_data   = r_slots;
    assign take_valid  = r_take_valid;

endmodule
`default_nettype wire
